// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
//   XLEN       register data width
//   NREG       number of architectural registers (power of 2), x0 hardwired zero
//   AW         register address width
//   reg_addr_t register index type
//   xlen_t     register data type
//   wb_req_t   one writeback request (destination + data)
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        reg_addr_t addr;
        xlen_t     data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset, pointer returns to 0
//   req      in   N request lines
//   accept   in   the current grant was taken; pointer moves past the winner
//   gnt      out  one-hot grant (combinational), all zero when nothing requests
//   gnt_idx  out  index of the granted line (valid when gnt != 0)
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 accept,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic          found;
    int            idx;

    // Scan starting at the pointer and wrap modulo N; first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && found) begin
            if (gnt_idx == PW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter and pending-write scoreboard.
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   req_valid    per-requester writeback pending
//   req_addr     per-requester destination register
//   req_data     per-requester write data
//   req_ready    one-hot grant this cycle; transfer = valid & ready
//   wr_en        registered regfile write enable
//   wr_addr      registered regfile write address
//   wr_data      registered regfile write data
//   issue_valid  decode issues an instruction that writes issue_rd
//   issue_rd     destination of the issued instruction
//   rs1_addr     decode source query 1
//   rs2_addr     decode source query 2
//   rs1_busy     register rs1_addr has a write outstanding
//   rs2_busy     register rs2_addr has a write outstanding
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  reg_addr_t [NREQ-1:0]  req_addr,
    input  xlen_t [NREQ-1:0]      req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  wr_en,
    output reg_addr_t             wr_addr,
    output xlen_t                 wr_data,
    input  logic                  issue_valid,
    input  reg_addr_t             issue_rd,
    input  reg_addr_t             rs1_addr,
    input  reg_addr_t             rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NREQ-1:0]         gnt;
    logic [$clog2(NREQ)-1:0] gnt_idx;
    logic                    xfer;
    wb_req_t                 win;
    logic [NREG-1:0]         pending;
    logic [NREG-1:0]         pending_nxt;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .accept  (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // No handshake may complete while reset is held, even if a source keeps valid up.
    assign req_ready = rst ? '0 : gnt;
    assign xfer      = |req_ready;

    always_comb begin
        win.addr = req_addr[gnt_idx];
        win.data = req_data[gnt_idx];
    end

    // Writes to x0 are accepted but never reach the port; address/data hold
    // so the port only changes on a real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (xfer && (win.addr != '0)) begin
            wr_en   <= 1'b1;
            wr_addr <= win.addr;
            wr_data <= win.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Clear is applied first so a same-edge issue of the register wins.
    always_comb begin
        pending_nxt = pending;
        if (wr_en) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rs1_busy = pending[rs1_addr];
    assign rs2_busy = pending[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    reg_addr_t [NREQ-1:0] req_addr;
    xlen_t [NREQ-1:0]     req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wr_en;
    reg_addr_t            wr_addr;
    xlen_t                wr_data;
    logic                 issue_valid;
    reg_addr_t            issue_rd;
    reg_addr_t            rs1_addr;
    reg_addr_t            rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: who is next in line, which registers await a write,
    // and what the write port should show.
    int              m_ptr;
    bit              m_pend[NREG];
    bit              m_wr_en;
    int              m_wr_addr;
    logic [XLEN-1:0] m_wr_data;
    logic [NREQ-1:0] last_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_wr_en   = 0;
        m_wr_addr = 0;
        m_wr_data = '0;
        last_gnt  = '0;
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    endtask

    // One clock cycle: check combinational outputs, advance the model on the
    // edge, then check the registered write port.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] eg;
        bit np[NREG];
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("rs1_busy", 64'(rs1_busy), 64'(m_pend[rs1_addr]));
        chk("rs2_busy", 64'(rs2_busy), 64'(m_pend[rs2_addr]));
        @(posedge clk);
        np = m_pend;
        if (m_wr_en) np[m_wr_addr] = 0;
        if (issue_valid && issue_rd != 0) np[issue_rd] = 1;
        m_pend = np;
        last_gnt = eg;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (req_addr[g] != 0) begin
                m_wr_en   = 1;
                m_wr_addr = int'(req_addr[g]);
                m_wr_data = req_data[g];
            end else begin
                m_wr_en = 0;
            end
        end else begin
            m_wr_en = 0;
        end
        #1;
        chk("wr_en", 64'(wr_en), 64'(m_wr_en));
        chk("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
        chk("wr_data", 64'(wr_data), 64'(m_wr_data));
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single source on requester 1
        req_valid   = 2'b10;
        req_addr[1] = 5'd3;
        req_data[1] = 32'hDEAD_BEEF;
        cycle();
        req_valid = 2'b00;
        cycle();

        // Both sources continuously: alternating grants
        req_valid   = 2'b11;
        req_addr[0] = 5'd5; req_data[0] = 32'h0000_000A;
        req_addr[1] = 5'd7; req_data[1] = 32'h0000_000B;
        repeat (4) cycle();
        req_valid = 2'b00;
        cycle();

        // x0 writeback: accepted, no write, pointer moves to 1
        req_valid   = 2'b01;
        req_addr[0] = 5'd0;
        req_data[0] = 32'h1234_5678;
        cycle();
        req_valid   = 2'b11;
        req_addr[0] = 5'd4;
        cycle();
        req_valid = 2'b00;
        cycle();

        // Scoreboard set then clear via writeback
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        rs1_addr    = 5'd9;
        rs2_addr    = 5'd0;
        cycle();
        issue_valid = 1'b0;
        cycle();
        req_valid   = 2'b01;
        req_addr[0] = 5'd9;
        req_data[0] = 32'hCAFE_0009;
        cycle();
        req_valid = 2'b00;
        repeat (2) cycle();

        // Set and clear of the same register on one edge
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        cycle();
        issue_valid = 1'b0;
        req_valid   = 2'b01;
        cycle();
        req_valid   = 2'b00;
        issue_valid = 1'b1;
        cycle();
        issue_valid = 1'b0;
        repeat (2) cycle();

        // Reset asserted mid-stream with both sources valid
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        rs2_addr    = 5'd12;
        req_valid   = 2'b11;
        req_addr[0] = 5'd5;
        req_addr[1] = 5'd7;
        cycle();
        issue_valid = 1'b0;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_wr_en", 64'(wr_en), 64'(0));
        chk("midrst_ready", 64'(req_ready), 64'(0));
        chk("midrst_rs1_busy", 64'(rs1_busy), 64'(0));
        chk("midrst_rs2_busy", 64'(rs2_busy), 64'(0));
        @(posedge clk);
        #1;
        chk("midrst_hold_wr_en", 64'(wr_en), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        cycle();
        req_valid = 2'b00;
        cycle();

        // Randomized traffic; requesters hold their request until granted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_gnt[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_addr[i]  = reg_addr_t'($urandom_range(0, 7));
                    req_data[i]  = xlen_t'($urandom);
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = reg_addr_t'($urandom_range(0, 7));
            rs1_addr    = reg_addr_t'($urandom_range(0, 7));
            rs2_addr    = reg_addr_t'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
